pipe_hazard_ctrl: RTL and testbench

Issue controller sitting between the instruction fetch and the registered instruction decoder of each core. It gates the decoder and PC enables, tracks in-flight register writes in a small scoreboard, and stalls decode with pipeline bubbles on read-after-write hazards. It also sequences core start, and drains the pipeline on halt.

---
 rtl/arya_pipe_pkg.sv | 23 ++
 rtl/pipe_scoreboard.sv | 65 ++++++
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/arya_pipe_pkg.sv
// -----------------------------------------------------------------------------
// arya_pipe_pkg
// Shared definitions for the pipeline hazard/issue controller.
//   REGFILE_ADDR  : default register address width
//   pipe_state_t  : issue FSM encoding (IDLE=0, RUN=1, DRAIN=2)
//   sb_entry_t    : one in-flight write record {vld, waddr}
// -----------------------------------------------------------------------------
package arya_pipe_pkg;

    localparam int REGFILE_ADDR = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic                    vld;
        logic [REGFILE_ADDR-1:0] waddr;
    } sb_entry_t;

endpackage

// File: rtl/pipe_scoreboard.sv
// -----------------------------------------------------------------------------
// pipe_scoreboard
// Shift register of in-flight register writes. Slot 0 is the youngest; every
// cycle all slots move one step older and the oldest is dropped.
// Ports:
//   clk, reset        : clock, async active-low reset (all slots invalid)
//   load_vld/waddr    : entry written into slot 0 this cycle
//   inst_valid        : decoder holds a real instruction
//   r0addr, r1addr    : source registers of the decoded instruction
//   hazard            : a valid slot matches either source (and inst_valid)
//   empty             : no slot holds a valid write
// -----------------------------------------------------------------------------
module pipe_scoreboard #(
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_vld,
    input  logic [ADDR_W-1:0] load_waddr,
    input  logic              inst_valid,
    input  logic [ADDR_W-1:0] r0addr,
    input  logic [ADDR_W-1:0] r1addr,
    output logic              hazard,
    output logic              empty
);

    logic              vld_q   [DEPTH];
    logic [ADDR_W-1:0] waddr_q [DEPTH];
    logic              match;
    logic              any_vld;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i]   <= 1'b0;
                waddr_q[i] <= '0;
            end
        end else begin
            vld_q[0]   <= load_vld;
            waddr_q[0] <= load_waddr;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]   <= vld_q[i-1];
                waddr_q[i] <= waddr_q[i-1];
            end
        end
    end

    // Register 0 is compared like any other register.
    always_comb begin
        match   = 1'b0;
        any_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) begin
                any_vld = 1'b1;
                if ((waddr_q[i] == r0addr) || (waddr_q[i] == r1addr))
                    match = 1'b1;
            end
        end
    end

    assign hazard = inst_valid & match;
    assign empty  = ~any_vld;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Issue controller between fetch and the registered decoder. Gates decoder/PC
// enables, inserts bubbles on read-after-write hazards, sequences start and
// drains the pipeline on halt.
// Optional feature macro: PIPE_CTRL_STALL_CNT_EN (hazard stall counter).
// Ports:
//   clk, reset              : clock, async active-low reset
//   start                   : one-cycle pulse, IDLE -> RUN
//   halt_req                : level, stop issuing and drain
//   inst_valid              : decoder output holds a real instruction
//   dec_r0addr, dec_r1addr  : decoded sources
//   dec_wregen, dec_wreg1   : decoded destination write enable / address
//   dec_en, pc_en, bubble   : combinational issue controls
//   running                 : state is RUN or DRAIN
//   done                    : one-cycle pulse after the drain completes
//   stall_cnt               : hazard stall cycles (0 when feature disabled)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int REGFILE_ADDR = arya_pipe_pkg::REGFILE_ADDR,
    parameter int PIPE_DEPTH   = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    halt_req,
    input  logic                    inst_valid,
    input  logic [REGFILE_ADDR-1:0] dec_r0addr,
    input  logic [REGFILE_ADDR-1:0] dec_r1addr,
    input  logic                    dec_wregen,
    input  logic [REGFILE_ADDR-1:0] dec_wreg1,
    output logic                    dec_en,
    output logic                    pc_en,
    output logic                    bubble,
    output logic                    running,
    output logic                    done,
    output logic [15:0]             stall_cnt
);

    // state | meaning
    // IDLE  | no issue, bubbles only, waiting for start
    // RUN   | issuing; stalls on hazard, fills on inst_valid=0
    // DRAIN | no issue; waits until scoreboard is empty, then IDLE + done

    import arya_pipe_pkg::*;

    pipe_state_t state;
    logic        done_q;
    logic        hazard;
    logic        sb_empty;
    logic        load_vld;

    pipe_scoreboard #(
        .ADDR_W (REGFILE_ADDR),
        .DEPTH  (PIPE_DEPTH)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .load_vld   (load_vld),
        .load_waddr (dec_wreg1),
        .inst_valid (inst_valid),
        .r0addr     (dec_r0addr),
        .r1addr     (dec_r1addr),
        .hazard     (hazard),
        .empty      (sb_empty)
    );

    // An empty decoder slot still advances fetch/decode so it can fill, but
    // nothing is issued, so execute sees a bubble.
    always_comb begin
        dec_en   = 1'b0;
        pc_en    = 1'b0;
        bubble   = 1'b1;
        load_vld = 1'b0;
        if (state == RUN && !halt_req) begin
            if (!inst_valid) begin
                dec_en = 1'b1;
                pc_en  = 1'b1;
            end else if (!hazard) begin
                dec_en   = 1'b1;
                pc_en    = 1'b1;
                bubble   = 1'b0;
                load_vld = dec_wregen;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !halt_req)
                        state <= RUN;
                end
                RUN: begin
                    if (halt_req)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (sb_empty) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign running = (state == RUN) || (state == DRAIN);
    assign done    = done_q;

`ifdef PIPE_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt_q;
    logic        start_accept;
    logic        hazard_stall;

    assign start_accept = (state == IDLE) && start && !halt_req;
    assign hazard_stall = (state == RUN) && !halt_req && hazard;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt_q <= '0;
        else if (start_accept)
            stall_cnt_q <= '0;
        else if (hazard_stall && stall_cnt_q != 16'hFFFF)
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        halt_req;
    logic        inst_valid;
    logic [2:0]  dec_r0addr;
    logic [2:0]  dec_r1addr;
    logic        dec_wregen;
    logic [2:0]  dec_wreg1;
    logic        dec_en;
    logic        pc_en;
    logic        bubble;
    logic        running;
    logic        done;
    logic [15:0] stall_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic  dec_en;
        logic  pc_en;
        logic  bubble;
        logic  running;
        logic  done;
        string name;
    } exp_t;

    exp_t exp_q[$];

    pipe_hazard_ctrl #(
        .REGFILE_ADDR (3),
        .PIPE_DEPTH   (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .halt_req   (halt_req),
        .inst_valid (inst_valid),
        .dec_r0addr (dec_r0addr),
        .dec_r1addr (dec_r1addr),
        .dec_wregen (dec_wregen),
        .dec_wreg1  (dec_wreg1),
        .dec_en     (dec_en),
        .pc_en      (pc_en),
        .bubble     (bubble),
        .running    (running),
        .done       (done),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock cycle: drive after the edge, push the expectation, then pop
    // and compare at the falling edge.
    task automatic step(input logic s, input logic h, input logic iv,
                        input logic [2:0] r0, input logic [2:0] r1,
                        input logic wen, input logic [2:0] w,
                        input logic e_dec, input logic e_pc, input logic e_bub,
                        input logic e_run, input logic e_done, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        start      = s;
        halt_req   = h;
        inst_valid = iv;
        dec_r0addr = r0;
        dec_r1addr = r1;
        dec_wregen = wen;
        dec_wreg1  = w;
        exp_q.push_back('{e_dec, e_pc, e_bub, e_run, e_done, nm});
        @(negedge clk);
        e = exp_q.pop_front();
        n_vec++;
        if (dec_en !== e.dec_en) begin
            n_miss++;
            $display("FAIL %s dec_en got %b want %b", e.name, dec_en, e.dec_en);
        end
        n_vec++;
        if (pc_en !== e.pc_en) begin
            n_miss++;
            $display("FAIL %s pc_en got %b want %b", e.name, pc_en, e.pc_en);
        end
        n_vec++;
        if (bubble !== e.bubble) begin
            n_miss++;
            $display("FAIL %s bubble got %b want %b", e.name, bubble, e.bubble);
        end
        n_vec++;
        if (running !== e.running) begin
            n_miss++;
            $display("FAIL %s running got %b want %b", e.name, running, e.running);
        end
        n_vec++;
        if (done !== e.done) begin
            n_miss++;
            $display("FAIL %s done got %b want %b", e.name, done, e.done);
        end
    endtask

    task automatic check_stall(input logic [15:0] want_en, input string nm);
        logic [15:0] want;
`ifdef PIPE_CTRL_STALL_CNT_EN
        want = want_en;
`else
        want = 16'h0000;
`endif
        n_vec++;
        if (stall_cnt !== want) begin
            n_miss++;
            $display("FAIL %s stall_cnt got %0d want %0d", nm, stall_cnt, want);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        n_vec++;
        if ({dec_en, pc_en, bubble, running, done} !== 5'b00100) begin
            n_miss++;
            $display("FAIL %s {dec_en,pc_en,bubble,running,done} got %b want 00100",
                     nm, {dec_en, pc_en, bubble, running, done});
        end
        n_vec++;
        if (stall_cnt !== 16'h0000) begin
            n_miss++;
            $display("FAIL %s stall_cnt got %0d want 0", nm, stall_cnt);
        end
    endtask

    // Three empty decoder cycles in RUN flush the scoreboard.
    task automatic flush_run(input string nm);
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 1, 1, 1, 1, 0, nm);
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        start      = 1'b0;
        halt_req   = 1'b0;
        inst_valid = 1'b0;
        dec_r0addr = 3'd0;
        dec_r1addr = 3'd0;
        dec_wregen = 1'b0;
        dec_wreg1  = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_held");
        @(posedge clk);
        #1 reset = 1'b1;
        step(0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, 0, 0, "idle_after_reset");
        step(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, 0, 0, "idle_start_cycle");
        step(0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 1, 1, 1, 1, 0, "run_after_start");
        check_stall(16'd0, "stall_after_start");
    endtask

    task automatic test_independent();
        for (int i = 0; i < 4; i++)
            step(0, 0, 1, 3'd1, 3'd2, 1, 3'(3 + i), 1, 1, 0, 1, 0, "indep_issue");
        flush_run("indep_flush");
        check_stall(16'd0, "stall_indep");
    endtask

    task automatic test_raw();
        step(0, 0, 1, 3'd0, 3'd1, 1, 3'd2, 1, 1, 0, 1, 0, "raw_writer");
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 3'd2, 3'd5, 1, 3'd6, 0, 0, 1, 1, 0, "raw_stall");
        step(0, 0, 1, 3'd2, 3'd5, 1, 3'd6, 1, 1, 0, 1, 0, "raw_resume");
        check_stall(16'd3, "stall_raw");
        flush_run("raw_flush");
    endtask

    task automatic test_gap();
        step(0, 0, 1, 3'd1, 3'd1, 1, 3'd5, 1, 1, 0, 1, 0, "gap_writer");
        step(0, 0, 1, 3'd1, 3'd1, 1, 3'd6, 1, 1, 0, 1, 0, "gap_indep");
        for (int i = 0; i < 2; i++)
            step(0, 0, 1, 3'd1, 3'd5, 0, 3'd0, 0, 0, 1, 1, 0, "gap_stall");
        step(0, 0, 1, 3'd1, 3'd5, 0, 3'd0, 1, 1, 0, 1, 0, "gap_resume");
        check_stall(16'd5, "stall_gap");
        flush_run("gap_flush");
    endtask

    task automatic test_drain();
        step(0, 0, 1, 3'd4, 3'd5, 1, 3'd1, 1, 1, 0, 1, 0, "drain_w1");
        step(0, 0, 1, 3'd4, 3'd5, 1, 3'd2, 1, 1, 0, 1, 0, "drain_w2");
        step(0, 0, 1, 3'd4, 3'd5, 1, 3'd3, 1, 1, 0, 1, 0, "drain_w3");
        step(0, 1, 1, 3'd4, 3'd5, 1, 3'd4, 0, 0, 1, 1, 0, "halt_cycle");
        step(1, 1, 1, 3'd4, 3'd5, 1, 3'd4, 0, 0, 1, 1, 0, "drain_1_start");
        step(1, 1, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, 1, 0, "drain_2_start");
        step(0, 1, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, 1, 0, "drain_3");
        step(0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, 0, 1, "done_pulse");
        step(1, 1, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, 0, 0, "idle_start_halt");
        step(0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, 0, 0, "idle_stays");
        step(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, 0, 0, "restart");
        step(0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 1, 1, 1, 1, 0, "rerun");
        check_stall(16'd0, "stall_cleared");
    endtask

    task automatic test_reset_mid_stall();
        step(0, 0, 1, 3'd0, 3'd1, 1, 3'd2, 1, 1, 0, 1, 0, "rst_writer");
        step(0, 0, 1, 3'd2, 3'd2, 0, 3'd0, 0, 0, 1, 1, 0, "rst_stall");
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("reset_async");
        @(posedge clk);
        #1 reset = 1'b1;
        step(1, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 1, 0, 0, "rst_restart");
        step(0, 0, 1, 3'd2, 3'd2, 0, 3'd0, 1, 1, 0, 1, 0, "rst_no_stale");
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw();
        test_gap();
        test_drain();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
